// File: rtl/core_pkg.sv
// Shared arbiter types: last-grant FSM encoding and response-select codes.
package core_pkg;

    typedef enum logic [1:0] {ARB_IDLE, ARB_FETCH, ARB_DATA} arb_state_t;

    localparam logic [1:0] RSP_SEL_NONE  = 2'd0;
    localparam logic [1:0] RSP_SEL_FETCH = 2'd1;
    localparam logic [1:0] RSP_SEL_DATA  = 2'd2;

endpackage

// File: rtl/memory_arbiter_if.sv
// Fetch, data and memory-side signals of the single-port memory arbiter.
interface memory_arbiter_if #(
    parameter int data_bits           = 32,
    parameter int memory_address_bits = 10
);
    logic                           if_req;
    logic [memory_address_bits-1:0] if_addr;
    logic                           if_gnt;
    logic                           if_rvalid;
    logic [data_bits-1:0]           if_rdata;

    logic                           dm_req;
    logic                           dm_we;
    logic [memory_address_bits-1:0] dm_addr;
    logic [data_bits-1:0]           dm_wdata;
    logic                           dm_gnt;
    logic                           dm_rvalid;
    logic [data_bits-1:0]           dm_rdata;

    logic                           mem_write_enable;
    logic                           mem_read_enable;
    logic [memory_address_bits-1:0] mem_address;
    logic [data_bits-1:0]           mem_input_data;
    logic [data_bits-1:0]           mem_output_data;

    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_output_data,
        output if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
               mem_write_enable, mem_read_enable, mem_address, mem_input_data
    );

    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_output_data,
        input  if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
               mem_write_enable, mem_read_enable, mem_address, mem_input_data
    );

endinterface

// File: rtl/arb_streak_counter.sv
// Saturating count of consecutive data grants taken while a fetch is waiting.
module arb_streak_counter #(
    parameter int max_data_streak = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic sat
);
    localparam int SW = $clog2(max_data_streak + 1);
    localparam logic [SW-1:0] MAX = SW'(max_data_streak);

    logic [SW-1:0] streak;

    always_ff @(posedge clk) begin
        if (!reset)
            streak <= '0;
        else if (clr)
            streak <= '0;
        else if (inc && !sat)
            streak <= streak + SW'(1);
    end

    assign sat = (streak == MAX);

endmodule

// File: rtl/memory_arbiter.sv
// Shares one memory port between fetch and load/store; data has priority,
// a bounded data streak guarantees the fetch path eventually gets a slot.
module memory_arbiter
    import core_pkg::*;
#(
    parameter int data_bits           = 32,
    parameter int memory_address_bits = 10,
    parameter int max_data_streak     = 4
) (
    input  logic             clk,
    input  logic             reset,
    memory_arbiter_if.slave  bus
);
    arb_state_t                     state_q, state_d;
    logic                           gnt_if, gnt_dm, sat;
    logic                           dm_load_q;
    logic [1:0]                     rsp_sel;
    logic [data_bits-1:0]           if_rdata_q, dm_rdata_q;
    logic                           mem_we, mem_re;
    logic [memory_address_bits-1:0] mem_addr;
    logic [data_bits-1:0]           mem_wdata;

    arb_streak_counter #(.max_data_streak(max_data_streak)) u_streak (
        .clk   (clk),
        .reset (reset),
        .inc   (gnt_dm && bus.if_req),
        .clr   (gnt_if || !bus.if_req),
        .sat   (sat)
    );

    always_ff @(posedge clk) begin
        if (!reset) state_q <= ARB_IDLE;
        else        state_q <= state_d;
    end

    // Fetch only beats a pending data request once the streak has saturated.
    always_comb begin
        gnt_if  = 1'b0;
        gnt_dm  = 1'b0;
        state_d = ARB_IDLE;
        if (reset) begin
            if (bus.dm_req && !(bus.if_req && sat)) begin
                gnt_dm  = 1'b1;
                state_d = ARB_DATA;
            end else if (bus.if_req) begin
                gnt_if  = 1'b1;
                state_d = ARB_FETCH;
            end
        end
    end

    always_comb begin
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (gnt_dm) begin
            mem_we    = bus.dm_we;
            mem_re    = !bus.dm_we;
            mem_addr  = bus.dm_addr;
            mem_wdata = bus.dm_wdata;
        end else if (gnt_if) begin
            mem_re   = 1'b1;
            mem_addr = bus.if_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
            dm_load_q  <= 1'b0;
        end else begin
            dm_load_q <= gnt_dm && !bus.dm_we;
            if (gnt_if)
                if_rdata_q <= bus.mem_output_data;
            if (gnt_dm && !bus.dm_we)
                dm_rdata_q <= bus.mem_output_data;
        end
    end

    // Responses are gated by reset so a read granted just before reset is dropped.
    always_comb begin
        rsp_sel = RSP_SEL_NONE;
        if (reset) begin
            if (state_q == ARB_FETCH)
                rsp_sel = RSP_SEL_FETCH;
            else if (state_q == ARB_DATA && dm_load_q)
                rsp_sel = RSP_SEL_DATA;
        end
    end

    assign bus.if_gnt           = gnt_if;
    assign bus.dm_gnt           = gnt_dm;
    assign bus.if_rvalid        = (rsp_sel == RSP_SEL_FETCH);
    assign bus.dm_rvalid        = (rsp_sel == RSP_SEL_DATA);
    assign bus.if_rdata         = reset ? if_rdata_q : '0;
    assign bus.dm_rdata         = reset ? dm_rdata_q : '0;
    assign bus.mem_write_enable = mem_we;
    assign bus.mem_read_enable  = mem_re;
    assign bus.mem_address      = mem_addr;
    assign bus.mem_input_data   = mem_wdata;

endmodule

// File: tb/tb_memory_arbiter.sv
// Per-cycle vector table for memory_arbiter plus a streak/store sequence.
module tb_memory_arbiter;
    localparam int DW  = 32;
    localparam int AW  = 10;
    localparam int MDS = 4;
    localparam logic [31:0] F5 = 32'h0050_0093;
    localparam logic [31:0] DB = 32'hDEAD_BEEF;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    memory_arbiter_if #(.data_bits(DW), .memory_address_bits(AW)) bus();

    memory_arbiter #(
        .data_bits(DW), .memory_address_bits(AW), .max_data_streak(MDS)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Memory model: pattern preload while in reset, writes at the grant edge.
    logic [DW-1:0] mem [0:1023];
    assign bus.mem_output_data = mem[bus.mem_address];
    always @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 32'hA000_0000 | i;
            mem[5] <= F5;
        end else if (bus.mem_write_enable) begin
            mem[bus.mem_address] <= bus.mem_input_data;
        end
    end

    typedef struct {
        logic        r;   logic        ir; logic [9:0]  ia;
        logic        dr;  logic        we; logic [9:0]  da; logic [31:0] wd;
        logic        ig;  logic        dg; logic        ivl; logic [31:0] id;
        logic        dvl; logic [31:0] dd; logic        mwe; logic        mre;
        logic [9:0]  ma;  logic [31:0] mwd;
    } vec_t;

    vec_t vq[$];
    int checks = 0;
    int errors = 0;

    function automatic logic [31:0] pat(int x);
        return 32'hA000_0000 | x;
    endfunction

    function automatic vec_t v(logic r, logic ir, int ia, logic dr, logic we, int da,
                               logic [31:0] wd, logic ig, logic dg, logic ivl,
                               logic [31:0] id, logic dvl, logic [31:0] dd,
                               logic mwe, logic mre, int ma, logic [31:0] mwd);
        vec_t t;
        t.r = r;  t.ir = ir; t.ia = 10'(ia); t.dr = dr; t.we = we; t.da = 10'(da);
        t.wd = wd; t.ig = ig; t.dg = dg; t.ivl = ivl; t.id = id; t.dvl = dvl;
        t.dd = dd; t.mwe = mwe; t.mre = mre; t.ma = 10'(ma); t.mwd = mwd;
        return t;
    endfunction

    task automatic chk(input string nm, input int row, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL row %0d %s: got %h expected %h", row, nm, act, exp);
        end
    endtask

    int  k;
    logic got;

    initial begin
        reset = 1'b0;
        bus.if_req = 0; bus.if_addr = '0; bus.dm_req = 0; bus.dm_we = 0;
        bus.dm_addr = '0; bus.dm_wdata = '0;

        //        r ir ia dr we da wd   ig dg ivl id       dvl dd       mwe mre ma mwd
        vq.push_back(v(0,1, 5,1,0, 3,0,  0,0,0,0,        0,0,        0,0, 0,0));
        vq.push_back(v(1,1, 5,0,0, 0,0,  1,0,0,0,        0,0,        0,1, 5,0));
        vq.push_back(v(1,0, 0,1,1, 8,DB, 0,1,1,F5,       0,0,        1,0, 8,DB));
        vq.push_back(v(1,0, 0,1,0, 8,0,  0,1,0,F5,       0,0,        0,1, 8,0));
        vq.push_back(v(1,0, 0,0,0, 0,0,  0,0,0,F5,       1,DB,       0,0, 0,0));
        vq.push_back(v(1,0, 0,0,0, 0,0,  0,0,0,F5,       0,DB,       0,0, 0,0));
        // contention: D,D,D,D,F,D
        vq.push_back(v(1,1,20,1,0,30,0,  0,1,0,F5,       0,DB,       0,1,30,0));
        vq.push_back(v(1,1,20,1,0,31,0,  0,1,0,F5,       1,pat(30),  0,1,31,0));
        vq.push_back(v(1,1,20,1,0,32,0,  0,1,0,F5,       1,pat(31),  0,1,32,0));
        vq.push_back(v(1,1,20,1,0,33,0,  0,1,0,F5,       1,pat(32),  0,1,33,0));
        vq.push_back(v(1,1,20,1,0,34,0,  1,0,0,F5,       1,pat(33),  0,1,20,0));
        vq.push_back(v(1,1,21,1,0,34,0,  0,1,1,pat(20),  0,pat(33),  0,1,34,0));
        vq.push_back(v(1,0, 0,0,0, 0,0,  0,0,0,pat(20),  1,pat(34),  0,0, 0,0));
        // fetch drops after 3 data grants: streak restarts
        vq.push_back(v(1,1,40,1,0,50,0,  0,1,0,pat(20),  0,pat(34),  0,1,50,0));
        vq.push_back(v(1,1,40,1,0,51,0,  0,1,0,pat(20),  1,pat(50),  0,1,51,0));
        vq.push_back(v(1,1,40,1,0,52,0,  0,1,0,pat(20),  1,pat(51),  0,1,52,0));
        vq.push_back(v(1,0, 0,1,0,53,0,  0,1,0,pat(20),  1,pat(52),  0,1,53,0));
        vq.push_back(v(1,1,40,1,0,54,0,  0,1,0,pat(20),  1,pat(53),  0,1,54,0));
        vq.push_back(v(1,1,40,1,0,55,0,  0,1,0,pat(20),  1,pat(54),  0,1,55,0));
        vq.push_back(v(1,1,40,1,0,56,0,  0,1,0,pat(20),  1,pat(55),  0,1,56,0));
        vq.push_back(v(1,1,40,1,0,57,0,  0,1,0,pat(20),  1,pat(56),  0,1,57,0));
        vq.push_back(v(1,1,40,1,0,58,0,  1,0,0,pat(20),  1,pat(57),  0,1,40,0));
        vq.push_back(v(1,0, 0,1,0,58,0,  0,1,1,pat(40),  0,pat(57),  0,1,58,0));
        // reset right after a load grant drops its response
        vq.push_back(v(1,0, 0,1,0,60,0,  0,1,0,pat(40),  1,pat(58),  0,1,60,0));
        vq.push_back(v(0,1,61,1,0,61,0,  0,0,0,0,        0,0,        0,0, 0,0));
        vq.push_back(v(1,0, 0,0,0, 0,0,  0,0,0,0,        0,0,        0,0, 0,0));
        vq.push_back(v(1,1, 5,0,0, 0,0,  1,0,0,0,        0,0,        0,1, 5,0));
        vq.push_back(v(1,0, 0,0,0, 0,0,  0,0,1,F5,       0,0,        0,0, 0,0));

        @(posedge clk); #1;
        foreach (vq[i]) begin
            reset       = vq[i].r;
            bus.if_req  = vq[i].ir;  bus.if_addr  = vq[i].ia;
            bus.dm_req  = vq[i].dr;  bus.dm_we    = vq[i].we;
            bus.dm_addr = vq[i].da;  bus.dm_wdata = vq[i].wd;
            @(negedge clk);
            chk("if_gnt",    i, 32'(bus.if_gnt),           32'(vq[i].ig));
            chk("dm_gnt",    i, 32'(bus.dm_gnt),           32'(vq[i].dg));
            chk("if_rvalid", i, 32'(bus.if_rvalid),        32'(vq[i].ivl));
            chk("if_rdata",  i, bus.if_rdata,              vq[i].id);
            chk("dm_rvalid", i, 32'(bus.dm_rvalid),        32'(vq[i].dvl));
            chk("dm_rdata",  i, bus.dm_rdata,              vq[i].dd);
            chk("mem_we",    i, 32'(bus.mem_write_enable), 32'(vq[i].mwe));
            chk("mem_re",    i, 32'(bus.mem_read_enable),  32'(vq[i].mre));
            chk("mem_addr",  i, 32'(bus.mem_address),      32'(vq[i].ma));
            chk("mem_wdata", i, bus.mem_input_data,        vq[i].mwd);
            @(posedge clk); #1;
        end

        // Stores stream against a waiting fetch: exactly MDS data grants first.
        bus.if_req = 1; bus.if_addr = 10'd7; bus.dm_req = 1; bus.dm_we = 1;
        k = 0; got = 0;
        for (int c = 0; c < 10 && !got; c++) begin
            bus.dm_addr  = 10'(100 + k);
            bus.dm_wdata = 32'h5000_0000 + k;
            @(negedge clk);
            if (bus.if_gnt) got = 1;
            else if (bus.dm_gnt) k++;
            @(posedge clk); #1;
        end
        chk("seq_fetch_granted", 100, 32'(got), 32'd1);
        chk("seq_data_streak",   100, k,        MDS);
        bus.if_req = 0;
        bus.dm_addr = 10'(100 + k); bus.dm_wdata = 32'h5000_0000 + k;
        @(negedge clk);
        chk("seq_dm_gnt",    101, 32'(bus.dm_gnt),    32'd1);
        chk("seq_if_rvalid", 101, 32'(bus.if_rvalid), 32'd1);
        chk("seq_if_rdata",  101, bus.if_rdata,       32'hA000_0007);
        @(posedge clk); #1;
        bus.dm_req = 0; bus.dm_we = 0;
        @(negedge clk);
        chk("seq_no_store_rvalid", 102, 32'(bus.dm_rvalid), 32'd0);
        chk("seq_mem103", 102, mem[103], 32'h5000_0003);
        chk("seq_mem104", 102, mem[104], 32'h5000_0004);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
